// File: rtl/sar_search.sv
// sar_search: successive-approximation controller for a 4-bit magnitude
// comparator. Drives the comparator B operand, reads back X (A > B) and
// recovers A one bit per cycle, MSB first.
// Optional feature macro: SAR_LED_EN (led mirrors result when defined,
// otherwise led is tied to zero).
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             x_in,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] led
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP     = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0]  IDX_ZERO    = {IDXW{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W       = WIDTH'(1);
  // First trial is the MSB candidate minus one, so X=1 means A >= candidate.
  localparam logic [WIDTH-1:0] FIRST_TRIAL = (ONE_W << (WIDTH - 1)) - ONE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [IDXW-1:0] idx_r;

  logic [WIDTH-1:0] bit_mask_s;
  logic [WIDTH-1:0] next_mask_s;
  logic [WIDTH-1:0] res_next_s;
  logic [WIDTH-1:0] trial_next_s;
  logic             last_bit_s;

  // Next partial result and next trial operand for the bit under test.
  always_comb begin
    bit_mask_s   = ONE_W << idx_r;
    next_mask_s  = bit_mask_s >> 1;
    res_next_s   = x_in ? (result | bit_mask_s) : result;
    // Candidate always has a bit set, so subtracting one cannot wrap.
    trial_next_s = (res_next_s | next_mask_s) - ONE_W;
    last_bit_s   = (idx_r == IDX_ZERO);
  end

  // Search sequencer: state, bit index and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= IDX_TOP;
      b_out   <= ZERO_W;
      result  <= ZERO_W;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= TEST;
            idx_r   <= IDX_TOP;
            result  <= ZERO_W;
            b_out   <= FIRST_TRIAL;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        TEST: begin
          result <= res_next_s;
          if (last_bit_s) begin
            state_r <= DONE;
            b_out   <= ZERO_W;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            idx_r   <= idx_r - IDXW'(1);
            b_out   <= trial_next_s;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        DONE: begin
          // start is deliberately ignored here; it is not queued.
          state_r <= IDLE;
          idx_r   <= IDX_TOP;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= IDX_TOP;
          b_out   <= ZERO_W;
          result  <= ZERO_W;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SAR_LED_EN
  // LED register follows result on the same edges, showing partial results.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= ZERO_W;
    end else if (state_r == IDLE && start) begin
      led <= ZERO_W;
    end else if (state_r == TEST) begin
      led <= res_next_s;
    end else begin
      led <= led;
    end
  end
`else
  assign led = ZERO_W;
`endif

endmodule
